// File: rtl/commit_trace_buf.sv
// commit_trace_buf: buffers up to two retired instructions per cycle from the
// ROB and replays them, oldest first, to a difftest checker that can hold off.
//
// Ports:
//   clock, reset                  single clock, synchronous active-high reset
//   rob_commit_valid[1:0]         retire-slot valids (bit0 = slot 1, older)
//   rob_commit_pc1/pc2            PCs of the retiring instructions
//   rob_commit_data1/data2        writeback data of the retiring instructions
//   diff_hold                     checker cannot accept entries this cycle
//   commit_valid[3:0]             {2'b00, slot2 valid, slot1 valid}, registered
//   commit_num[7:0]               number of valid output slots, registered
//   commit_pc1/pc2/data1/data2    output slot payloads, zero when not valid
//   rob_stall                     fewer than two free entries (from count)
//   overflow                      sticky: an incoming entry was dropped
//
// Optional feature (macro COMMIT_TRACE_PERF_EN):
//   perf_retired[31:0]            total entries popped (wraps)
//   perf_hold[31:0]               cycles with diff_hold=1 and count>0 (wraps)

module commit_trace_buf #(
  parameter int unsigned DEPTH = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [1:0]  rob_commit_valid,
  input  logic [31:0] rob_commit_pc1,
  input  logic [31:0] rob_commit_pc2,
  input  logic [31:0] rob_commit_data1,
  input  logic [31:0] rob_commit_data2,
  input  logic        diff_hold,
  output logic [3:0]  commit_valid,
  output logic [7:0]  commit_num,
  output logic [31:0] commit_pc1,
  output logic [31:0] commit_pc2,
  output logic [31:0] commit_data1,
  output logic [31:0] commit_data2,
  output logic        rob_stall,
`ifdef COMMIT_TRACE_PERF_EN
  output logic [31:0] perf_retired,
  output logic [31:0] perf_hold,
`endif
  output logic        overflow
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] data;
  } entry_t;

  entry_t        mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;

  logic [1:0]    n_in;
  logic [1:0]    n_push;
  logic [1:0]    n_pop;
  logic [CW-1:0] free;
  logic [CW-1:0] count_nxt;
  logic          drop;
  entry_t        first;
  entry_t        second;
  logic [AW-1:0] wr_ptr_p1;
  logic [AW-1:0] rd_ptr_p1;

  assign rob_stall = (count > CW'(DEPTH - 2));

  // Push/pop sizing; pops use count at cycle start so fresh pushes wait a cycle.
  always_comb begin
    n_in      = 2'(rob_commit_valid[0]) + 2'(rob_commit_valid[1]);
    free      = CW'(DEPTH) - count;
    n_push    = n_in;
    drop      = 1'b0;
    n_pop     = 2'd0;
    wr_ptr_p1 = AW'(wr_ptr + AW'(1));
    rd_ptr_p1 = AW'(rd_ptr + AW'(1));
    if (CW'(n_in) > free) begin
      n_push = free[1:0];
      drop   = 1'b1;
    end
    if (!diff_hold) begin
      n_pop = (count >= CW'(2)) ? 2'd2 : count[1:0];
    end
    count_nxt = count + CW'(n_push) - CW'(n_pop);
    // The older valid slot is always written first; slot 2 alone goes first too.
    first  = rob_commit_valid[0] ? entry_t'{rob_commit_pc1, rob_commit_data1}
                                 : entry_t'{rob_commit_pc2, rob_commit_data2};
    second = entry_t'{rob_commit_pc2, rob_commit_data2};
  end

  // Storage; writes only land in free slots so they never collide with reads.
  always_ff @(posedge clock) begin
    if (!reset) begin
      if (n_push != 2'd0) mem[wr_ptr]    <= first;
      if (n_push == 2'd2) mem[wr_ptr_p1] <= second;
    end
  end

  // Pointers, occupancy, sticky overflow and registered output slots.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      overflow     <= 1'b0;
      commit_valid <= '0;
      commit_num   <= '0;
      commit_pc1   <= '0;
      commit_pc2   <= '0;
      commit_data1 <= '0;
      commit_data2 <= '0;
    end else begin
      wr_ptr       <= AW'(wr_ptr + AW'(n_push));
      rd_ptr       <= AW'(rd_ptr + AW'(n_pop));
      count        <= count_nxt;
      overflow     <= overflow | drop;
      commit_valid <= {2'b00, n_pop == 2'd2, n_pop != 2'd0};
      commit_num   <= 8'(n_pop);
      commit_pc1   <= (n_pop != 2'd0) ? mem[rd_ptr].pc      : 32'd0;
      commit_data1 <= (n_pop != 2'd0) ? mem[rd_ptr].data    : 32'd0;
      commit_pc2   <= (n_pop == 2'd2) ? mem[rd_ptr_p1].pc   : 32'd0;
      commit_data2 <= (n_pop == 2'd2) ? mem[rd_ptr_p1].data : 32'd0;
    end
  end

`ifdef COMMIT_TRACE_PERF_EN
  // Performance counters; free-running and wrapping.
  always_ff @(posedge clock) begin
    if (reset) begin
      perf_retired <= '0;
      perf_hold    <= '0;
    end else begin
      perf_retired <= perf_retired + 32'(n_pop);
      if (diff_hold && (count != '0)) perf_hold <= perf_hold + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_commit_trace_buf.sv
// Self-checking bench for commit_trace_buf: a queue model of the buffer
// predicts each cycle's output slots; predictions are queued when stimulus is
// driven and compared after the following clock edge.

module tb_commit_trace_buf;

  localparam int unsigned DEPTH = 8;

  logic        clock = 1'b0;
  logic        reset;
  logic [1:0]  rob_commit_valid;
  logic [31:0] rob_commit_pc1, rob_commit_pc2;
  logic [31:0] rob_commit_data1, rob_commit_data2;
  logic        diff_hold;
  logic [3:0]  commit_valid;
  logic [7:0]  commit_num;
  logic [31:0] commit_pc1, commit_pc2, commit_data1, commit_data2;
  logic        rob_stall;
  logic        overflow;
`ifdef COMMIT_TRACE_PERF_EN
  logic [31:0] perf_retired, perf_hold;
  logic [31:0] m_retired, m_hold;
`endif

  typedef struct packed {
    logic [3:0]  valid;
    logic [7:0]  num;
    logic [31:0] pc1;
    logic [31:0] pc2;
    logic [31:0] d1;
    logic [31:0] d2;
  } exp_t;

  logic [63:0] mq[$];
  exp_t        eq[$];
  logic        m_ovf;
  int          checks = 0;
  int          errors = 0;

  commit_trace_buf #(.DEPTH(DEPTH)) dut (
    .clock            (clock),
    .reset            (reset),
    .rob_commit_valid (rob_commit_valid),
    .rob_commit_pc1   (rob_commit_pc1),
    .rob_commit_pc2   (rob_commit_pc2),
    .rob_commit_data1 (rob_commit_data1),
    .rob_commit_data2 (rob_commit_data2),
    .diff_hold        (diff_hold),
    .commit_valid     (commit_valid),
    .commit_num       (commit_num),
    .commit_pc1       (commit_pc1),
    .commit_pc2       (commit_pc2),
    .commit_data1     (commit_data1),
    .commit_data2     (commit_data2),
    .rob_stall        (rob_stall),
`ifdef COMMIT_TRACE_PERF_EN
    .perf_retired     (perf_retired),
    .perf_hold        (perf_hold),
`endif
    .overflow         (overflow)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One clock cycle: drive inputs, predict, clock, compare.
  task automatic step(input logic rst, input logic [1:0] v, input logic [31:0] p1,
                      input logic [31:0] d1, input logic [31:0] p2, input logic [31:0] d2,
                      input logic hold);
    exp_t        e;
    int          npop;
    int          free;
    logic [63:0] ent;
    reset = rst; rob_commit_valid = v; diff_hold = hold;
    rob_commit_pc1 = p1; rob_commit_data1 = d1;
    rob_commit_pc2 = p2; rob_commit_data2 = d2;
    e = '0;
    if (rst) begin
      mq.delete();
      m_ovf = 1'b0;
`ifdef COMMIT_TRACE_PERF_EN
      m_retired = '0; m_hold = '0;
`endif
    end else begin
      free = DEPTH - mq.size();
      npop = hold ? 0 : ((mq.size() >= 2) ? 2 : mq.size());
`ifdef COMMIT_TRACE_PERF_EN
      m_retired += 32'(npop);
      if (hold && mq.size() > 0) m_hold += 32'd1;
`endif
      if (npop >= 1) begin
        ent = mq.pop_front();
        e.valid = 4'b0001; e.num = 8'd1; e.pc1 = ent[63:32]; e.d1 = ent[31:0];
      end
      if (npop == 2) begin
        ent = mq.pop_front();
        e.valid = 4'b0011; e.num = 8'd2; e.pc2 = ent[63:32]; e.d2 = ent[31:0];
      end
      if (v[0]) begin
        if (free > 0) begin mq.push_back({p1, d1}); free--; end
        else m_ovf = 1'b1;
      end
      if (v[1]) begin
        if (free > 0) begin mq.push_back({p2, d2}); free--; end
        else m_ovf = 1'b1;
      end
    end
    eq.push_back(e);
    @(posedge clock);
    #1;
    e = eq.pop_front();
    check("valid", 64'(commit_valid), 64'(e.valid));
    check("num",   64'(commit_num),   64'(e.num));
    check("pc1",   64'(commit_pc1),   64'(e.pc1));
    check("data1", 64'(commit_data1), 64'(e.d1));
    check("pc2",   64'(commit_pc2),   64'(e.pc2));
    check("data2", 64'(commit_data2), 64'(e.d2));
    check("rob_stall", 64'(rob_stall), 64'(mq.size() > DEPTH - 2));
    check("overflow",  64'(overflow),  64'(m_ovf));
`ifdef COMMIT_TRACE_PERF_EN
    check("perf_retired", 64'(perf_retired), 64'(m_retired));
    check("perf_hold",    64'(perf_hold),    64'(m_hold));
`endif
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 2'b00, '0, '0, '0, '0, 1'b0);
  endtask

  initial begin
    m_ovf = 1'b0;
`ifdef COMMIT_TRACE_PERF_EN
    m_retired = '0; m_hold = '0;
`endif
    step(1'b1, 2'b11, 32'h1, 32'h2, 32'h3, 32'h4, 1'b0);
    step(1'b1, 2'b00, '0, '0, '0, '0, 1'b0);

    // Single slot-1 push, visible two cycles later.
    step(1'b0, 2'b01, 32'h8000_0000, 32'd5, 32'h0, 32'h0, 1'b0);
    idle(1);
    check("single_pc1", 64'(commit_pc1), 64'h8000_0000);
    check("single_num", 64'(commit_num), 64'd1);
    idle(1);

    // Dual push.
    step(1'b0, 2'b11, 32'h100, 32'hA, 32'h104, 32'hB, 1'b0);
    idle(1);
    check("dual_pc2", 64'(commit_pc2), 64'h104);
    idle(1);

    // Slot-2-only push lands in output slot 1.
    step(1'b0, 2'b10, 32'h0, 32'h0, 32'h200, 32'h22, 1'b0);
    idle(1);
    check("slot2only_pc1", 64'(commit_pc1), 64'h200);
    idle(1);

    // Hold for 10 cycles pushing 2 per cycle: fills, stalls, then overflows.
    for (int i = 0; i < 10; i++)
      step(1'b0, 2'b11, 32'h1000 + 32'(8 * i), 32'(i), 32'h1004 + 32'(8 * i), 32'(100 + i), 1'b1);
    check("hold_ovf", 64'(overflow), 64'd1);
    idle(6);
    check("ovf_sticky", 64'(overflow), 64'd1);

    // Reset with 5 entries buffered; stale entries must never appear.
    step(1'b0, 2'b11, 32'h3000, 32'h1, 32'h3004, 32'h2, 1'b1);
    step(1'b0, 2'b11, 32'h3008, 32'h3, 32'h300C, 32'h4, 1'b1);
    step(1'b0, 2'b01, 32'h3010, 32'h5, 32'h0, 32'h0, 1'b1);
    step(1'b1, 2'b11, 32'hDEAD, 32'hDEAD, 32'hBEEF, 32'hBEEF, 1'b0);
    check("rst_stall", 64'(rob_stall), 64'd0);
    check("rst_ovf", 64'(overflow), 64'd0);
    step(1'b0, 2'b01, 32'h4000, 32'h40, 32'h0, 32'h0, 1'b0);
    idle(3);

    // Random traffic that honours rob_stall; exercises wrap and mixed pops.
    for (int i = 0; i < 400; i++) begin
      logic [1:0] v;
      v = 2'($urandom_range(0, 3));
      if (mq.size() > DEPTH - 2) v = 2'b00;
      step(1'b0, v, $urandom, $urandom, $urandom, $urandom, ($urandom_range(0, 3) == 0));
    end
    idle(6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
